// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD result writer:
// mode encodings, HD44780 command bytes, ASCII codes and a divider-free decimal helper.
package lcd_pkg;

   typedef enum logic [1:0] {
      MODE_READY  = 2'd0,
      MODE_TRAIN  = 2'd1,
      MODE_DONE   = 2'd2,
      MODE_RESULT = 2'd3
   } mode_t;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_HASH  = 8'h23;
   localparam logic [7:0] ASC_DASH  = 8'h2D;
   localparam logic [7:0] ASC_PCT   = 8'h25;
   localparam logic [7:0] ASC_0     = 8'h30;

   typedef struct packed {
      mode_t      mode;
      logic       is_o;
      logic [6:0] pct;
      logic [7:0] epoch;
   } snap_t;

   typedef enum logic [1:0] {BW_IDLE, BW_SETUP, BW_PULSE, BW_WAIT} bw_phase_t;

   typedef enum logic [2:0] {
      S_PWRON, S_INIT, S_IDLE, S_L1_ADDR, S_L1_CHR, S_L2_ADDR, S_L2_CHR
   } lcd_state_t;

   // Returns {hundreds, tens, ones} as BCD nibbles using compare-and-subtract.
   function automatic logic [11:0] dec3(input logic [7:0] v);
      logic [7:0] r;
      logic [3:0] h;
      logic [3:0] t;
      r = v;
      h = 4'd0;
      t = 4'd0;
      if (r >= 8'd200) begin
         h = 4'd2;
         r = r - 8'd200;
      end else if (r >= 8'd100) begin
         h = 4'd1;
         r = r - 8'd100;
      end
      for (int i = 0; i < 9; i++) begin
         if (r >= 8'd10) begin
            r = r - 8'd10;
            t = t + 4'd1;
         end
      end
      return {h, t, r[3:0]};
   endfunction

   function automatic logic [7:0] asc_digit(input logic [3:0] d);
      return ASC_0 | {4'h0, d};
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Purpose: one HD44780 byte write - setup cycle, lcd_e pulse, then settle wait with rs/data held.
// Latency: 1 + E_PULSE_CYC + wait cycles (CLR_WAIT_CYC after command 0x01, else CMD_WAIT_CYC).
// Backpressure: start is accepted only when idle or on the done cycle, so bytes chain with no gap.
module lcd_byte_writer import lcd_pkg::*; #(
   parameter int E_PULSE_CYC  = 25,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       done
);

   bw_phase_t   phase, phase_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic        rs_nxt;
   logic [7:0]  data_nxt;
   logic        accept;
   logic        is_clr;

   assign done   = (phase == BW_WAIT) && (cnt == 32'd0);
   assign accept = start && ((phase == BW_IDLE) || done);
   assign is_clr = !lcd_rs && (lcd_data == CMD_CLEAR);
   assign lcd_e  = (phase == BW_PULSE);

   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      rs_nxt    = lcd_rs;
      data_nxt  = lcd_data;
      if (accept) begin
         phase_nxt = BW_SETUP;
         rs_nxt    = rs;
         data_nxt  = data;
      end else begin
         case (phase)
            BW_SETUP: begin
               phase_nxt = BW_PULSE;
               cnt_nxt   = 32'(E_PULSE_CYC - 1);
            end
            BW_PULSE: begin
               if (cnt == 32'd0) begin
                  phase_nxt = BW_WAIT;
                  cnt_nxt   = is_clr ? 32'(CLR_WAIT_CYC - 1) : 32'(CMD_WAIT_CYC - 1);
               end else begin
                  cnt_nxt = cnt - 32'd1;
               end
            end
            BW_WAIT: begin
               if (cnt == 32'd0) phase_nxt = BW_IDLE;
               else              cnt_nxt   = cnt - 32'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= BW_IDLE;
         cnt      <= 32'd0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
      end else begin
         phase    <= phase_nxt;
         cnt      <= cnt_nxt;
         lcd_rs   <= rs_nxt;
         lcd_data <= data_nxt;
      end
   end

endmodule

// File: rtl/lcd_result_writer.sv
// Purpose: init the 16x2 LCD once, then redraw status (line 1) and O-probability (line 2) per upd_req.
// Latency: a redraw is 34 byte writes; busy stays high until it, and any pending redraw, completes.
// Backpressure: upd_req while busy is held in a single newest-wins slot. LCD_BAR_EN adds a bar graph.
module lcd_result_writer import lcd_pkg::*; #(
   parameter int PWRON_WAIT_CYC = 1000000,
   parameter int E_PULSE_CYC    = 25,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLR_WAIT_CYC   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       upd_req,
   input  logic [1:0] mode,
   input  logic       is_O,
   input  logic [6:0] prob_pct,
   input  logic [7:0] epoch,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rw,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   lcd_state_t  state, state_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [31:0] pwr_cnt;
   logic        pending;
   snap_t       snap, snap_pend, snap_in;
   logic        launch, load_pend;
   logic        bw_rs, bw_done;
   logic [7:0]  bw_data;

   assign snap_in = {mode, is_O, prob_pct, epoch};
   assign busy    = (state != S_IDLE);
   assign lcd_rw  = 1'b0;

   function automatic logic [7:0] pick(input logic [127:0] txt, input logic [3:0] col);
      logic [6:0] sel;
      sel = {4'd15 - col, 3'b000};
      return txt[sel +: 8];
   endfunction

   function automatic logic [7:0] line1_char(input snap_t s, input logic [3:0] col);
      logic [127:0] txt;
      logic [11:0]  d;
      d = dec3(s.epoch);
      case (s.mode)
         MODE_TRAIN:  txt = {"TRAIN EPOCH ", asc_digit(d[11:8]), asc_digit(d[7:4]),
                             asc_digit(d[3:0]), ASC_SPACE};
         MODE_DONE:   txt = "TRAIN DONE      ";
         MODE_RESULT: txt = {"RESULT: ", (s.is_o ? 8'h4F : 8'h58), {7{ASC_SPACE}}};
         default:     txt = "READY           ";
      endcase
      return pick(txt, col);
   endfunction

   function automatic logic [7:0] line2_char(input snap_t s, input logic [3:0] col);
      logic [127:0] txt;
      logic [6:0]   p;
      logic [11:0]  d;
`ifdef LCD_BAR_EN
      logic [3:0]   n;
`endif
      p   = (s.pct > 7'd100) ? 7'd100 : s.pct;
      d   = dec3({1'b0, p});
      txt = {16{ASC_SPACE}};
      if (s.mode == MODE_RESULT) begin
`ifdef LCD_BAR_EN
         // Ten bar cells in columns 5..14; 100% is the only value with a hundreds digit.
         n   = (d[11:8] != 4'd0) ? 4'd10 : d[7:4];
         txt = {asc_digit(d[11:8]), asc_digit(d[7:4]), asc_digit(d[3:0]), ASC_PCT,
                {12{ASC_SPACE}}};
         for (int i = 0; i < 10; i++)
            txt[(10 - i)*8 +: 8] = (4'(i) < n) ? ASC_HASH : ASC_DASH;
`else
         txt = {"PROB(O): ", asc_digit(d[11:8]), asc_digit(d[7:4]), asc_digit(d[3:0]),
                ASC_PCT, {3{ASC_SPACE}}};
`endif
      end
      return pick(txt, col);
   endfunction

   // Next byte is chosen from the next state so consecutive transactions abut.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      launch    = 1'b0;
      load_pend = 1'b0;
      case (state)
         S_PWRON: if (pwr_cnt == 32'(PWRON_WAIT_CYC - 1)) begin
            state_nxt = S_INIT;
            idx_nxt   = 4'd0;
            launch    = 1'b1;
         end
         S_INIT: if (bw_done) begin
            launch = 1'b1;
            if (idx == 4'd3) begin
               state_nxt = S_L1_ADDR;
               idx_nxt   = 4'd0;
            end else idx_nxt = idx + 4'd1;
         end
         S_IDLE: if (upd_req) begin
            state_nxt = S_L1_ADDR;
            idx_nxt   = 4'd0;
            launch    = 1'b1;
         end
         S_L1_ADDR: if (bw_done) begin
            state_nxt = S_L1_CHR;
            idx_nxt   = 4'd0;
            launch    = 1'b1;
         end
         S_L1_CHR: if (bw_done) begin
            launch = 1'b1;
            if (idx == 4'd15) begin
               state_nxt = S_L2_ADDR;
               idx_nxt   = 4'd0;
            end else idx_nxt = idx + 4'd1;
         end
         S_L2_ADDR: if (bw_done) begin
            state_nxt = S_L2_CHR;
            idx_nxt   = 4'd0;
            launch    = 1'b1;
         end
         S_L2_CHR: if (bw_done) begin
            if (idx != 4'd15) begin
               idx_nxt = idx + 4'd1;
               launch  = 1'b1;
            end else if (pending) begin
               state_nxt = S_L1_ADDR;
               idx_nxt   = 4'd0;
               launch    = 1'b1;
               load_pend = 1'b1;
            end else begin
               state_nxt = S_IDLE;
               idx_nxt   = 4'd0;
            end
         end
         default: state_nxt = S_PWRON;
      endcase

      bw_rs   = 1'b0;
      bw_data = 8'h00;
      case (state_nxt)
         S_INIT: case (idx_nxt[1:0])
            2'd0:    bw_data = CMD_FUNC_SET;
            2'd1:    bw_data = CMD_DISP_ON;
            2'd2:    bw_data = CMD_ENTRY;
            default: bw_data = CMD_CLEAR;
         endcase
         S_L1_ADDR: bw_data = CMD_LINE1;
         S_L1_CHR: begin
            bw_rs   = 1'b1;
            bw_data = line1_char(snap, idx_nxt);
         end
         S_L2_ADDR: bw_data = CMD_LINE2;
         S_L2_CHR: begin
            bw_rs   = 1'b1;
            bw_data = line2_char(snap, idx_nxt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_PWRON;
         idx       <= 4'd0;
         pwr_cnt   <= 32'd0;
         pending   <= 1'b0;
         snap      <= '0;
         snap_pend <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         pwr_cnt <= (state == S_PWRON) ? pwr_cnt + 32'd1 : 32'd0;
         if (state == S_IDLE && upd_req) snap <= snap_in;
         else if (load_pend)             snap <= snap_pend;
         if (upd_req && busy) begin
            pending   <= 1'b1;
            snap_pend <= snap_in;
         end else if (load_pend) begin
            pending <= 1'b0;
         end
      end
   end

   lcd_byte_writer #(
      .E_PULSE_CYC (E_PULSE_CYC),
      .CMD_WAIT_CYC(CMD_WAIT_CYC),
      .CLR_WAIT_CYC(CLR_WAIT_CYC)
   ) u_byte (
      .clk     (clk),
      .rst     (rst),
      .start   (launch),
      .rs      (bw_rs),
      .data    (bw_data),
      .lcd_e   (lcd_e),
      .lcd_rs  (lcd_rs),
      .lcd_data(lcd_data),
      .done    (bw_done)
   );

endmodule
